// File: rtl/countdown_sequencer_pkg.sv
// Shared constants for the countdown sequencer: FSM state encoding and default width.
// No logic; latency and backpressure are defined by the modules that import it.
// Kept separate so the controller-side blocks can share the state encoding.
package countdown_sequencer_pkg;

    localparam int N_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/down_counter_core.sv
// Loadable N-bit down counter with synchronous clear and a zero flag (bout).
// Latency: load/decrement/clear take effect at the next rising edge.
// Backpressure: none internally; the caller gates en with the consumer handshake.
module down_counter_core #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         loadEn,
    input  logic [N-1:0] initCount,
    input  logic         en,
    input  logic         clear,
    output logic [N-1:0] count,
    output logic         bout
);

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (loadEn) begin
            count_d = initCount;
        end else if (en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    // Zero is terminal: the caller sees bout before it would ever request a decrement past 0.
    assign bout  = ~|count_q;

endmodule

// File: rtl/countdown_sequencer.sv
// Streams init_count, init_count-1, ..., 0 to a valid/ready consumer, then pulses done.
// Latency: start accepted at edge k -> first beat valid in cycle k+1; one beat per cycle at full rate.
// Backpressure: count and valid hold while ready=0; valid/last depend only on registered state.
module countdown_sequencer
    import countdown_sequencer_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] init_count,
    input  logic         abort,
    input  logic         ready,
    output logic [N-1:0] count,
    output logic         valid,
    output logic         last,
    output logic         busy,
    output logic         done
);

    state_e state_q;
    state_e state_d;

    logic   beat;
    logic   bout;
    logic   load_en;
    logic   dec_en;

    assign valid   = (state_q == ST_RUN);
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign beat    = valid && ready;
    assign last    = valid && bout;
    assign load_en = start && (state_q == ST_IDLE) && !abort;
    assign dec_en  = beat && !bout;

    down_counter_core #(
        .N (N)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .loadEn    (load_en),
        .initCount (init_count),
        .en        (dec_en),
        .clear     (abort),
        .count     (count),
        .bout      (bout)
    );

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start)       state_d = ST_RUN;
                ST_RUN:  if (beat && bout) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
